// File: rtl/jailbreak_loader_pkg.sv
// jailbreak_loader_pkg: shared states, ioctl indices and ROM region map for the Jailbreak loader
package jailbreak_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOADING, HOLD, RUN} ld_state_t;
  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_DIP = 8'd254;
  localparam logic [17:0] CPU_END  = 18'h0FFFF;
  localparam logic [17:0] TILE_END = 18'h17FFF;
  localparam logic [17:0] SPR_END  = 18'h27FFF;
  localparam logic [17:0] PROM_END = 18'h281FF;
  localparam logic [17:0] VLM_END  = 18'h2A1FF;
  localparam logic [17:0] CPU_BASE  = 18'h0;
  localparam logic [17:0] TILE_BASE = CPU_END + 18'd1;
  localparam logic [17:0] SPR_BASE  = TILE_END + 18'd1;
  localparam logic [17:0] PROM_BASE = SPR_END + 18'd1;
  localparam logic [17:0] VLM_BASE  = PROM_END + 18'd1;
  localparam int RST_HOLD = 16;
  localparam int HOLD_W = $clog2(RST_HOLD);
  typedef struct packed {
    logic cpu;
    logic tile;
    logic spr;
    logic prom;
    logic vlm;
  } region_t;
endpackage

// File: rtl/jailbreak_region_decode.sv
// jailbreak_region_decode: maps an ioctl byte address to a one-hot ROM region and region offset
module jailbreak_region_decode
  import jailbreak_loader_pkg::*;
(
  input  logic [24:0] addr,
  output region_t     region,
  output logic [15:0] offset,
  output logic        oversize
);
  logic [17:0] a;
  assign a = addr[17:0];
  always_comb begin
    oversize = (|addr[24:18]) || (a > VLM_END);
    region = '{
      cpu:  !oversize && a <= CPU_END,
      tile: !oversize && a > CPU_END && a <= TILE_END,
      spr:  !oversize && a > TILE_END && a <= SPR_END,
      prom: !oversize && a > SPR_END && a <= PROM_END,
      vlm:  !oversize && a > PROM_END
    };
    offset = 16'(a - (region.tile ? TILE_BASE : region.spr ? SPR_BASE :
                      region.prom ? PROM_BASE : region.vlm ? VLM_BASE : CPU_BASE));
  end
endmodule

// File: rtl/jailbreak_rom_loader.sv
// jailbreak_rom_loader: decodes the HPS ioctl stream into Jailbreak ROM writes, DIP banks and core reset
module jailbreak_rom_loader
  import jailbreak_loader_pkg::*;
(
  input  logic        clk_49m,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        cpu_wr,
  output logic [15:0] cpu_addr,
  output logic [7:0]  rom_data,
  output logic        tile_wr,
  output logic [14:0] tile_addr,
  output logic        prom_wr,
  output logic [8:0]  prom_addr,
  output logic        vlm_wr,
  output logic [12:0] vlm_addr,
  output logic        spr_wr,
  output logic [14:0] spr_addr,
  output logic [15:0] spr_data,
  output logic [23:0] dip_sw,
  output logic        rom_loaded,
  output logic        rom_oversize,
  output logic        core_reset_n
);
  region_t region;
  logic [15:0] offset;
  logic oversize;
  logic rom_wr, dip_wr, byte_wr, spr_even, spr_odd;
  logic start, finish, done;
  ld_state_t state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [7:0] spr_lat;

  jailbreak_region_decode u_dec (
    .addr(ioctl_addr),
    .region(region),
    .offset(offset),
    .oversize(oversize)
  );

  assign rom_wr   = ioctl_wr && ioctl_download && ioctl_index == IDX_ROM;
  assign dip_wr   = ioctl_wr && ioctl_download && ioctl_index == IDX_DIP;
  assign byte_wr  = rom_wr && (region.cpu || region.tile || region.prom || region.vlm);
  assign spr_even = rom_wr && region.spr && !offset[0];
  assign spr_odd  = rom_wr && region.spr && offset[0];

  always_comb begin
    start = ioctl_download && ioctl_index == IDX_ROM && (state == IDLE || state == RUN);
    finish = state == LOADING && !ioctl_download && ioctl_index == IDX_ROM;
    done = state == HOLD && hold_cnt == '0;
    state_nxt = start ? LOADING : finish ? HOLD : done ? RUN : state;
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hold_cnt <= '0;
      rom_loaded <= 1'b0;
      rom_oversize <= 1'b0;
      core_reset_n <= 1'b0;
      cpu_wr <= 1'b0;
      tile_wr <= 1'b0;
      prom_wr <= 1'b0;
      vlm_wr <= 1'b0;
      spr_wr <= 1'b0;
      cpu_addr <= '0;
      tile_addr <= '0;
      prom_addr <= '0;
      vlm_addr <= '0;
      spr_addr <= '0;
      spr_data <= '0;
      rom_data <= '0;
      spr_lat <= '0;
      dip_sw <= 24'hFFFFFF;
    end else begin
      state <= state_nxt;
      hold_cnt <= finish ? HOLD_W'(RST_HOLD - 1) : (state == HOLD && hold_cnt != '0) ? hold_cnt - 1'b1 : hold_cnt;
      rom_loaded <= start ? 1'b0 : done ? 1'b1 : rom_loaded;
      // An oversize byte arriving on the start cycle still counts against the new image.
      rom_oversize <= (rom_wr && oversize) || (rom_oversize && !start);
      core_reset_n <= state_nxt == RUN;
      cpu_wr <= rom_wr && region.cpu;
      tile_wr <= rom_wr && region.tile;
      prom_wr <= rom_wr && region.prom;
      vlm_wr <= rom_wr && region.vlm;
      spr_wr <= spr_odd;
      if (byte_wr) rom_data <= ioctl_dout;
      if (rom_wr && region.cpu) cpu_addr <= offset;
      if (rom_wr && region.tile) tile_addr <= offset[14:0];
      if (rom_wr && region.prom) prom_addr <= offset[8:0];
      if (rom_wr && region.vlm) vlm_addr <= offset[12:0];
      spr_lat <= start ? 8'h00 : spr_even ? ioctl_dout : spr_lat;
      if (spr_odd) begin
        spr_addr <= offset[15:1];
        spr_data <= {ioctl_dout, spr_lat};
      end
      if (dip_wr && ioctl_addr < 25'd3) dip_sw[{ioctl_addr[1:0], 3'b000} +: 8] <= ioctl_dout;
    end
  end
endmodule

// File: tb/tb_jailbreak_rom_loader.sv
// tb_jailbreak_rom_loader: scoreboard bench for the ioctl ROM loader
module tb_jailbreak_rom_loader;
  logic clk_49m = 1'b0;
  logic reset = 1'b1;
  logic ioctl_download = 1'b0;
  logic [7:0] ioctl_index = 8'd0;
  logic ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0;
  logic cpu_wr, tile_wr, prom_wr, vlm_wr, spr_wr;
  logic [15:0] cpu_addr, spr_data;
  logic [7:0] rom_data;
  logic [14:0] tile_addr, spr_addr;
  logic [8:0] prom_addr;
  logic [12:0] vlm_addr;
  logic [23:0] dip_sw;
  logic rom_loaded, rom_oversize, core_reset_n;

  jailbreak_rom_loader dut (
    .clk_49m(clk_49m), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .rom_data(rom_data),
    .tile_wr(tile_wr), .tile_addr(tile_addr), .prom_wr(prom_wr), .prom_addr(prom_addr),
    .vlm_wr(vlm_wr), .vlm_addr(vlm_addr), .spr_wr(spr_wr), .spr_addr(spr_addr), .spr_data(spr_data),
    .dip_sw(dip_sw), .rom_loaded(rom_loaded), .rom_oversize(rom_oversize), .core_reset_n(core_reset_n)
  );

  always #5 clk_49m = ~clk_49m;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] addr;
    logic [15:0] data;
    logic [31:0] when;
  } ev_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  ev_t sb[$];
  logic [7:0] m_lat = 8'h00;

  always @(posedge clk_49m) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk_49m) begin
    int n;
    ev_t o, e;
    n = int'(cpu_wr) + int'(tile_wr) + int'(spr_wr) + int'(prom_wr) + int'(vlm_wr);
    if (n > 1) check("multi_strobe", 64'(n), 64'd1);
    if (n > 0) begin
      o.kind = cpu_wr ? 3'd1 : tile_wr ? 3'd2 : spr_wr ? 3'd3 : prom_wr ? 3'd4 : 3'd5;
      o.addr = cpu_wr ? cpu_addr : tile_wr ? {1'b0, tile_addr} : spr_wr ? {1'b0, spr_addr} :
               prom_wr ? {7'd0, prom_addr} : {3'd0, vlm_addr};
      o.data = spr_wr ? spr_data : {8'h00, rom_data};
      o.when = cyc;
      if (sb.size() == 0) check("unexpected_strobe", 64'(o.kind), 64'd0);
      else begin
        e = sb.pop_front();
        check("region", 64'(o.kind), 64'(e.kind));
        check("addr", 64'(o.addr), 64'(e.addr));
        check("data", 64'(o.data), 64'(e.data));
        check("latency", 64'(o.when), 64'(e.when));
      end
    end
  end

  task automatic model(input logic [24:0] a, input logic [7:0] d);
    ev_t e;
    logic [17:0] off;
    e.when = cyc + 1;
    e.data = {8'h00, d};
    if (a > 25'h2A1FF) return;
    if (a <= 25'h0FFFF) begin
      e.kind = 3'd1; e.addr = a[15:0];
    end else if (a <= 25'h17FFF) begin
      e.kind = 3'd2; e.addr = 16'(a - 25'h10000);
    end else if (a <= 25'h27FFF) begin
      off = 18'(a - 25'h18000);
      if (!off[0]) begin
        m_lat = d;
        return;
      end
      e.kind = 3'd3; e.addr = 16'(off >> 1); e.data = {d, m_lat};
    end else if (a <= 25'h281FF) begin
      e.kind = 3'd4; e.addr = 16'(a - 25'h28000);
    end else begin
      e.kind = 3'd5; e.addr = 16'(a - 25'h28200);
    end
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_49m);
  endtask

  task automatic put(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_49m);
    ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    if (idx == 8'd0 && ioctl_download) model(a, d);
    @(negedge clk_49m);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk_49m);
    ioctl_index = idx; ioctl_download = 1'b1;
    if (idx == 8'd0) m_lat = 8'h00;
    tick(2);
  endtask

  task automatic end_dl(input logic [7:0] idx);
    @(negedge clk_49m);
    ioctl_index = idx; ioctl_download = 1'b0;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    do begin
      @(negedge clk_49m);
      n++;
    end while (!core_reset_n && n < 100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_core_reset_n", 64'(core_reset_n), 64'd0);
    check("rst_rom_loaded", 64'(rom_loaded), 64'd0);
    check("rst_oversize", 64'(rom_oversize), 64'd0);
    check("rst_dip_sw", 64'(dip_sw), 64'hFFFFFF);
    check("rst_strobes", 64'({cpu_wr, tile_wr, spr_wr, prom_wr, vlm_wr}), 64'd0);

    start_dl(8'd0);
    put(8'd0, 25'h0FFFF, 8'hA5);
    put(8'd0, 25'h10000, 8'h3C);
    put(8'd0, 25'h17FFF, 8'h5E);
    put(8'd0, 25'h18002, 8'h11);
    put(8'd0, 25'h18003, 8'h22);
    put(8'd0, 25'h27FFE, 8'h9A);
    put(8'd0, 25'h27FFF, 8'hBC);
    put(8'd0, 25'h28000, 8'h01);
    put(8'd0, 25'h281FF, 8'h02);
    put(8'd0, 25'h28200, 8'h03);
    put(8'd0, 25'h2A1FF, 8'h04);
    put(8'd7, 25'h00010, 8'h77);
    for (int i = 0; i < 24; i++)
      put(8'd0, 25'($urandom_range(0, 32'h2A1FF)), 8'($urandom));
    tick(2);
    check("sb_drained_load", 64'(sb.size()), 64'd0);
    check("loading_reset_n", 64'(core_reset_n), 64'd0);
    end_dl(8'd0);
    wait_run(n);
    check("hold_cycles", 64'(n), 64'(16 + 1));
    check("loaded", 64'(rom_loaded), 64'd1);
    check("no_oversize", 64'(rom_oversize), 64'd0);

    start_dl(8'd254);
    put(8'd254, 25'd0, 8'hFE);
    put(8'd254, 25'd1, 8'h7F);
    put(8'd254, 25'd2, 8'h5A);
    put(8'd254, 25'd3, 8'h00);
    end_dl(8'd254);
    tick(2);
    check("dip_sw", 64'(dip_sw), 64'h5A7FFE);
    check("dip_keeps_loaded", 64'(rom_loaded), 64'd1);
    check("dip_keeps_run", 64'(core_reset_n), 64'd1);

    start_dl(8'd0);
    check("restart_unloaded", 64'(rom_loaded), 64'd0);
    check("restart_reset_n", 64'(core_reset_n), 64'd0);
    put(8'd0, 25'h2A200, 8'hEE);
    tick(1);
    check("oversize_set", 64'(rom_oversize), 64'd1);
    put(8'd0, 25'h18001, 8'h44);
    end_dl(8'd0);
    wait_run(n);
    check("hold_cycles_2", 64'(n), 64'd17);
    check("loaded_with_oversize", 64'(rom_loaded), 64'd1);
    check("oversize_sticky", 64'(rom_oversize), 64'd1);
    start_dl(8'd0);
    check("oversize_cleared", 64'(rom_oversize), 64'd0);
    put(8'd0, 25'h0040000, 8'h99);
    tick(1);
    check("oversize_hi_bits", 64'(rom_oversize), 64'd1);
    put(8'd254, 25'd1, 8'h12);
    put(8'd0, 25'h00100, 8'h55);
    tick(1);
    check("sb_drained_mid", 64'(sb.size()), 64'd0);

    #3 reset = 1'b1;
    #1;
    check("arst_reset_n", 64'(core_reset_n), 64'd0);
    check("arst_loaded", 64'(rom_loaded), 64'd0);
    check("arst_oversize", 64'(rom_oversize), 64'd0);
    check("arst_dip", 64'(dip_sw), 64'hFFFFFF);
    check("arst_outputs", 64'({cpu_addr, spr_data, rom_data, spr_addr}), 64'd0);
    ioctl_download = 1'b0;
    m_lat = 8'h00;
    tick(2);
    reset = 1'b0;
    tick(30);
    check("arst_idle_reset_n", 64'(core_reset_n), 64'd0);
    check("arst_idle_loaded", 64'(rom_loaded), 64'd0);

    start_dl(8'd0);
    put(8'd0, 25'h18005, 8'h66);
    put(8'd0, 25'h00042, 8'h24);
    end_dl(8'd0);
    wait_run(n);
    check("hold_cycles_3", 64'(n), 64'd17);
    check("loaded_3", 64'(rom_loaded), 64'd1);
    tick(2);
    check("sb_drained_end", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
